// File: rtl/debounce_bank_pkg.sv
// rtl/debounce_bank_pkg.sv - shared types and helpers for the button conditioner
package debounce_bank_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, symmetric debounce, edge pulses, auto-repeat
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int CNT_MAX    = 250000,
    parameter int ACTIVE_LOW = 0,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic clean,
    output logic press,
    output logic release_pulse,
    output logic press_next
);

    localparam int             CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    // Raw pin level meaning "not pressed"; flops reset here so no false edge follows reset.
    localparam logic           IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             settle;
    logic             rise;
    logic             fall;
    logic             repeat_fire;

    assign level  = sync2 ^ IDLE_RAW;
    assign settle = (level != clean) && (cnt == CNT_LAST);
    assign rise   = settle && !clean;
    assign fall   = settle && clean;
    // Release wins over a repeat that would land in the same cycle.
    assign press_next = rise || (repeat_fire && !fall);

    // Two-flop synchroniser on the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (level == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            clean <= level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Register single-cycle press/release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= press_next;
            release_pulse <= fall;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rpt
            localparam int RPT_W = max_int($clog2(max_int(REPEAT_DLY, REPEAT_PER)), 1);
            localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
            localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

            rpt_state_t       state;
            logic [RPT_W-1:0] timer;

            assign repeat_fire = ((state == HELD) && (timer == DLY_LAST)) ||
                                 ((state == REPEATING) && (timer == PER_LAST));

            // Hold-to-repeat sequencer: initial delay, then a fixed repeat period.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= RELEASED;
                    timer <= '0;
                end else if (fall) begin
                    state <= RELEASED;
                    timer <= '0;
                end else begin
                    case (state)
                        RELEASED: begin
                            if (rise) begin
                                state <= HELD;
                                timer <= '0;
                            end
                        end
                        HELD: begin
                            if (timer == DLY_LAST) begin
                                state <= REPEATING;
                                timer <= '0;
                            end else begin
                                timer <= timer + RPT_W'(1);
                            end
                        end
                        REPEATING: begin
                            if (timer == PER_LAST) begin
                                timer <= '0;
                            end else begin
                                timer <= timer + RPT_W'(1);
                            end
                        end
                        default: begin
                            state <= RELEASED;
                            timer <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_no_rpt
            assign repeat_fire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel button conditioner with combined press flag
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_MAX    = 250000,
    parameter int ACTIVE_LOW = 0,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_press
);

    logic [N_CH-1:0] press_next;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_channel #(
                .CNT_MAX    (CNT_MAX),
                .ACTIVE_LOW (ACTIVE_LOW),
                .REPEAT_EN  (REPEAT_EN),
                .REPEAT_DLY (REPEAT_DLY),
                .REPEAT_PER (REPEAT_PER)
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .button        (button[i]),
                .clean         (clean[i]),
                .press         (press[i]),
                .release_pulse (release_pulse[i]),
                .press_next    (press_next[i])
            );
        end
    endgenerate

    // Reduce the per-channel next-press terms so any_press lines up with press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - directed self-checking bench for debounce_bank
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_a, btn_l, btn_r;
    logic [3:0] clean_a, press_a, rel_a;
    logic [3:0] clean_l, press_l, rel_l;
    logic [3:0] clean_r, press_r, rel_r;
    logic       any_a, any_l, any_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(4), .CNT_MAX(4), .ACTIVE_LOW(0), .REPEAT_EN(0),
                    .REPEAT_DLY(8), .REPEAT_PER(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .button(btn_a), .clean(clean_a),
        .press(press_a), .release_pulse(rel_a), .any_press(any_a));

    debounce_bank #(.N_CH(4), .CNT_MAX(4), .ACTIVE_LOW(1), .REPEAT_EN(0),
                    .REPEAT_DLY(8), .REPEAT_PER(3)) dut_l (
        .clk(clk), .rst_n(rst_n), .button(btn_l), .clean(clean_l),
        .press(press_l), .release_pulse(rel_l), .any_press(any_l));

    debounce_bank #(.N_CH(4), .CNT_MAX(4), .ACTIVE_LOW(0), .REPEAT_EN(1),
                    .REPEAT_DLY(8), .REPEAT_PER(3)) dut_r (
        .clk(clk), .rst_n(rst_n), .button(btn_r), .clean(clean_r),
        .press(press_r), .release_pulse(rel_r), .any_press(any_r));

    typedef struct {
        logic [3:0] btn;
        logic [3:0] clean;
        logic [3:0] press;
        logic [3:0] rel;
        logic       any;
    } vec_t;

    vec_t tbl[1:20];

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name, input int cyc);
        check({name, "_a"}, cyc, {clean_a, press_a, rel_a, 3'b000, any_a}, 32'h0);
        check({name, "_l"}, cyc, {clean_l, press_l, rel_l, 3'b000, any_l}, 32'h0);
        check({name, "_r"}, cyc, {clean_r, press_r, rel_r, 3'b000, any_r}, 32'h0);
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic reset_pulse(input string name);
        #2 rst_n = 1'b0;
        #1 check_all_zero(name, 0);
        #2 rst_n = 1'b1;
    endtask

    // After reset with buttons held, every held channel re-debounces from scratch.
    task automatic check_redebounce(input string name);
        for (int j = 1; j <= 7; j++) begin
            step();
            check({name, "_clean_a"}, j, clean_a, (j >= 6) ? 4'b0001 : 4'b0000);
            check({name, "_clean_l"}, j, clean_l, (j >= 6) ? 4'b1000 : 4'b0000);
            check({name, "_clean_r"}, j, clean_r, (j >= 6) ? 4'b0001 : 4'b0000);
            check({name, "_press_r"}, j, press_r, (j == 6) ? 4'b0001 : 4'b0000);
            check({name, "_any_r"}, j, any_r, (j == 6));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_a = 4'h0;
        btn_l = 4'hF;
        btn_r = 4'h0;

        step();
        step();
        check_all_zero("reset", 0);
        rst_n = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            check_all_zero("idle", j);
        end

        // Scenario 1 + 2: ch0 rises before edge 10; ch1 bounces 1,1,0,1,1,1,0...
        for (int i = 1; i <= 20; i++) begin
            tbl[i].btn   = {2'b00, ((i % 4) != 3), (i >= 10)};
            tbl[i].clean = (i >= 15) ? 4'b0001 : 4'b0000;
            tbl[i].press = (i == 15) ? 4'b0001 : 4'b0000;
            tbl[i].rel   = 4'b0000;
            tbl[i].any   = (i == 15);
        end
        for (int i = 1; i <= 20; i++) begin
            btn_a = tbl[i].btn;
            step();
            check("tbl_clean", i, clean_a, tbl[i].clean);
            check("tbl_press", i, press_a, tbl[i].press);
            check("tbl_rel", i, rel_a, tbl[i].rel);
            check("tbl_any", i, any_a, tbl[i].any);
        end
        btn_a[1] = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            check("bounce_settle", j, {clean_a, press_a, rel_a}, {4'b0001, 4'b0000, 4'b0000});
        end

        // Scenario 3: ch2 press, then release path.
        btn_a[2] = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            check("s3_rise_clean", j, clean_a, (j >= 6) ? 4'b0101 : 4'b0001);
            check("s3_rise_press", j, press_a, (j == 6) ? 4'b0100 : 4'b0000);
        end
        btn_a[2] = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            step();
            check("s3_fall_clean", j, clean_a, (j < 6) ? 4'b0101 : 4'b0001);
            check("s3_fall_rel", j, rel_a, (j == 6) ? 4'b0100 : 4'b0000);
            check("s3_fall_press", j, press_a, 4'b0000);
            check("s3_fall_any", j, any_a, 1'b0);
        end

        // Scenario 4: active-low channel 3.
        btn_l[3] = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            step();
            check("s4_clean", j, clean_l, (j >= 6) ? 4'b1000 : 4'b0000);
            check("s4_press", j, press_l, (j == 6) ? 4'b1000 : 4'b0000);
            check("s4_rel", j, rel_l, 4'b0000);
            check("s4_any", j, any_l, (j == 6));
        end

        // Scenario 5: auto-repeat; release lands on a would-be repeat cycle (38).
        btn_r[0] = 1'b1;
        for (int j = 1; j <= 41; j++) begin
            logic exp_p;
            if (j == 33) btn_r[0] = 1'b0;
            step();
            exp_p = (j == 6) || (j == 14) || (j >= 17 && j < 38 && ((j - 17) % 3) == 0);
            check("s5_press", j, press_r, {3'b000, exp_p});
            check("s5_any", j, any_r, exp_p);
            check("s5_rel", j, rel_r, (j == 38) ? 4'b0001 : 4'b0000);
            check("s5_clean", j, clean_r, (j >= 6 && j < 38) ? 4'b0001 : 4'b0000);
        end

        // Scenario 6: reset mid-count, then mid-repeat.
        btn_r[0] = 1'b1;
        step();
        step();
        step();
        reset_pulse("s6_midcount_rst");
        check_redebounce("s6a");
        for (int j = 1; j <= 12; j++) step();
        check("s6_in_repeat", 0, clean_r, 4'b0001);
        reset_pulse("s6_midrepeat_rst");
        check_redebounce("s6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
